cmd_router: RTL and testbench

- Parametrised successor to the fixed 5-destination command decoder.
- Parses the UART receive byte stream (AXI-stream style valid/ready) into framed packets: SYNC, DEST, LEN, payload, and an optional checksum.
- Forwards each payload byte, with per-channel backpressure, to one of N_CH destination channels.
- Adds invalid-destination draining, an inter-byte timeout, completion and error strobes, and debug taps.

---
 rtl/cmd_router.sv | 222 ++++++++++++++++++++++
 tb/tb_cmd_router.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_router.sv
// cmd_router: parses a UART byte stream into SYNC/DEST/LEN/payload packets and
// forwards the payload to one of N_CH channels with per-channel backpressure.
// Packets to unknown destinations are drained. An inter-byte timeout aborts
// stalled packets.
// Optional trailing checksum byte: define CMD_ROUTER_CHECKSUM_EN.
module cmd_router #(
   parameter int unsigned N_CH    = 5,
   parameter int unsigned LEN_W   = 8,
   parameter logic [7:0]  SYNC    = 8'hAA,
   parameter int unsigned TIMEOUT = 48000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic [N_CH*8-1:0] data_bus,
   output logic [N_CH-1:0]   valid_bus,
   input  logic [N_CH-1:0]   ready_bus,
   output logic              pkt_done,
   output logic              err_dest,
   output logic              err_timeout,
   output logic              err_csum,
   output logic [2:0]        my_state,
   output logic [7:0]        my_dest,
   output logic [LEN_W-1:0]  my_len,
   output logic [LEN_W-1:0]  my_cnt
);

   // TIMEOUT >= 2, so TIMEOUT-1 always fits in clog2(TIMEOUT) bits.
   localparam int unsigned   TO_W   = $clog2(TIMEOUT);
   localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StDest    = 3'd1,
      StLen     = 3'd2,
      StPayload = 3'd3,
      StDrop    = 3'd4,
      StCsum    = 3'd5
   } state_e;

   state_e            state_q, state_d;
   logic [7:0]        dest_q;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  cnt_q;
   logic [TO_W-1:0]   to_cnt_q;
   logic              pkt_done_q, pkt_done_d;
   logic              err_dest_q, err_dest_d;
   logic              err_timeout_q, err_timeout_d;

   logic xfer;
   logic timeout_hit;
   logic last_byte;
   logic dest_ok;
   logic len_zero;

   assign xfer        = rx_valid && rx_ready;
   // A stall with rx_valid high never counts, so only a silent link can expire.
   assign timeout_hit = (state_q != StIdle) && !rx_valid && (to_cnt_q == TO_MAX);
   assign last_byte   = (cnt_q == (len_q - LEN_W'(1)));
   assign dest_ok     = (32'(dest_q) < N_CH);
   assign len_zero    = (rx_data[LEN_W-1:0] == '0);

`ifdef CMD_ROUTER_CHECKSUM_EN
   logic [7:0] csum_q;
   logic       drop_q;
   logic       err_csum_q, err_csum_d;

   // Running XOR of DEST, LEN and payload; remembers whether the packet was drained.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         csum_q     <= 8'h00;
         drop_q     <= 1'b0;
         err_csum_q <= 1'b0;
      end else begin
         err_csum_q <= err_csum_d;
         if (state_q == StIdle) begin
            csum_q <= 8'h00;
            drop_q <= 1'b0;
         end else if (xfer && (state_q != StCsum)) begin
            csum_q <= csum_q ^ rx_data;
            if (state_q == StLen) drop_q <= !len_zero && !dest_ok;
         end
      end
   end

   assign err_csum = err_csum_q;
`else
   assign err_csum = 1'b0;
`endif

   // State register and registered one-cycle strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         pkt_done_q    <= 1'b0;
         err_dest_q    <= 1'b0;
         err_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pkt_done_q    <= pkt_done_d;
         err_dest_q    <= err_dest_d;
         err_timeout_q <= err_timeout_d;
      end
   end

   // Next-state and strobe decode.
   always_comb begin
      state_d       = state_q;
      pkt_done_d    = 1'b0;
      err_dest_d    = 1'b0;
      err_timeout_d = 1'b0;
`ifdef CMD_ROUTER_CHECKSUM_EN
      err_csum_d    = 1'b0;
`endif
      if (timeout_hit) begin
         state_d       = StIdle;
         err_timeout_d = 1'b1;
      end else if (xfer) begin
         unique case (state_q)
            StIdle: begin
               if (rx_data == SYNC) state_d = StDest;
            end
            StDest: begin
               state_d = StLen;
            end
            StLen: begin
               if (len_zero) begin
`ifdef CMD_ROUTER_CHECKSUM_EN
                  state_d = StCsum;
`else
                  state_d    = StIdle;
                  pkt_done_d = 1'b1;
`endif
               end else if (dest_ok) begin
                  state_d = StPayload;
               end else begin
                  state_d    = StDrop;
                  err_dest_d = 1'b1;
               end
            end
            StPayload, StDrop: begin
               if (last_byte) begin
`ifdef CMD_ROUTER_CHECKSUM_EN
                  state_d = StCsum;
`else
                  state_d    = StIdle;
                  pkt_done_d = (state_q == StPayload);
`endif
               end
            end
`ifdef CMD_ROUTER_CHECKSUM_EN
            StCsum: begin
               state_d = StIdle;
               if (rx_data == csum_q) pkt_done_d = !drop_q;
               else                   err_csum_d = 1'b1;
            end
`endif
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   // Packet header latches, payload counter and idle-link counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dest_q   <= 8'h00;
         len_q    <= '0;
         cnt_q    <= '0;
         to_cnt_q <= '0;
      end else begin
         if (state_q == StIdle || xfer || timeout_hit) begin
            to_cnt_q <= '0;
         end else if (!rx_valid) begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
         end

         if (timeout_hit) begin
            cnt_q <= '0;
         end else if (xfer) begin
            if (state_q == StDest) dest_q <= rx_data;
            if (state_q == StLen) begin
               len_q <= rx_data[LEN_W-1:0];
               cnt_q <= '0;
            end
            if (state_q == StPayload || state_q == StDrop) cnt_q <= cnt_q + LEN_W'(1);
         end
      end
   end

   // Output decode: zero-latency pass-through to the selected channel in PAYLOAD.
   always_comb begin
      rx_ready  = 1'b0;
      data_bus  = '0;
      valid_bus = '0;
      if (rst_n) begin
         if (state_q == StPayload) begin
            for (int k = 0; k < N_CH; k++) begin
               if (dest_q == 8'(k)) begin
                  data_bus[8*k +: 8] = rx_data;
                  valid_bus[k]       = rx_valid;
                  rx_ready           = ready_bus[k];
               end
            end
         end else begin
            rx_ready = 1'b1;
         end
      end
   end

   assign pkt_done    = pkt_done_q;
   assign err_dest    = err_dest_q;
   assign err_timeout = err_timeout_q;
   assign my_state    = state_q;
   assign my_dest     = dest_q;
   assign my_len      = len_q;
   assign my_cnt      = cnt_q;

endmodule

// File: tb/tb_cmd_router.sv
// Scoreboard bench for cmd_router: stimulus pushes expected channel bytes and
// strobes into queues; a negedge monitor pops and compares them.
module tb_cmd_router;

   localparam int unsigned N_CH    = 5;
   localparam int unsigned LEN_W   = 8;
   localparam int unsigned TIMEOUT = 8;

   localparam logic [3:0] S_DONE = 4'b0001;
   localparam logic [3:0] S_DEST = 4'b0010;
   localparam logic [3:0] S_TO   = 4'b0100;
   localparam logic [3:0] S_CSUM = 4'b1000;

   logic              clk;
   logic              rst_n;
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic [N_CH*8-1:0] data_bus;
   logic [N_CH-1:0]   valid_bus;
   logic [N_CH-1:0]   ready_bus;
   logic              pkt_done;
   logic              err_dest;
   logic              err_timeout;
   logic              err_csum;
   logic [2:0]        my_state;
   logic [7:0]        my_dest;
   logic [LEN_W-1:0]  my_len;
   logic [LEN_W-1:0]  my_cnt;

   int errors = 0;
   int checks = 0;

   logic [15:0] exp_data[$];
   logic [3:0]  exp_strb[$];

   cmd_router #(
      .N_CH    (N_CH),
      .LEN_W   (LEN_W),
      .SYNC    (8'hAA),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready),
      .data_bus    (data_bus),
      .valid_bus   (valid_bus),
      .ready_bus   (ready_bus),
      .pkt_done    (pkt_done),
      .err_dest    (err_dest),
      .err_timeout (err_timeout),
      .err_csum    (err_csum),
      .my_state    (my_state),
      .my_dest     (my_dest),
      .my_len      (my_len),
      .my_cnt      (my_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void check(input string name, input logic [31:0] act,
                                 input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endfunction

   // Monitor: pops expected channel bytes on handshakes and expected strobes on pulses.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int k = 0; k < N_CH; k++) begin
            if (valid_bus[k] && ready_bus[k]) begin
               if (exp_data.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_data: got ch %0d byte %0h, required none", k,
                           data_bus[8*k +: 8]);
               end else begin
                  check("chan_data", {8'(k), data_bus[8*k +: 8]}, 32'(exp_data.pop_front()));
               end
            end
         end
         if ({err_csum, err_timeout, err_dest, pkt_done} != 4'b0000) begin
            if (exp_strb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_strobe: got %b, required none",
                        {err_csum, err_timeout, err_dest, pkt_done});
            end else begin
               check("strobe", {28'd0, err_csum, err_timeout, err_dest, pkt_done},
                     32'(exp_strb.pop_front()));
            end
         end
      end
   end

   // Present one byte and hold it until accepted (bounded).
   task automatic send_byte(input logic [7:0] b);
      int n;
      bit done;
      n    = 0;
      done = 1'b0;
      rx_data  = b;
      rx_valid = 1'b1;
      while (!done) begin
         @(negedge clk);
         if (rx_ready) begin
            done = 1'b1;
         end else begin
            n++;
            if (n > 100) begin
               checks++;
               errors++;
               $display("FAIL send_timeout: byte %0h not accepted, rx_ready=%b", b, rx_ready);
               done = 1'b1;
            end
         end
      end
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   // Checksum byte only exists in the checksum build.
   task automatic send_csum(input logic [7:0] b);
`ifdef CMD_ROUTER_CHECKSUM_EN
      send_byte(b);
`else
      if (b == 8'hxx) $display("unused %0h", b);
`endif
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      rx_data   = 8'h00;
      rx_valid  = 1'b1;
      ready_bus = '1;
      #23;
      check("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
      check("rst_valid_bus", 32'(valid_bus), 32'd0);
      rx_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rst_state", 32'(my_state), 32'd0);
      check("rst_regs", {my_dest, my_len, my_cnt, 8'd0}, 32'd0);
      check("rst_strobes", {28'd0, err_csum, err_timeout, err_dest, pkt_done}, 32'd0);
      check("idle_ready", {31'd0, rx_ready}, 32'd1);

      // 1: normal packet to channel 2.
      exp_data.push_back({8'd2, 8'h11});
      exp_data.push_back({8'd2, 8'h22});
      exp_data.push_back({8'd2, 8'h33});
      exp_strb.push_back(S_DONE);
      send_byte(8'hAA);
      send_byte(8'h02);
      send_byte(8'h03);
      check("t1_state_payload", 32'(my_state), 32'd3);
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      send_csum(8'h01);
      check("t1_pkt_done", {31'd0, pkt_done}, 32'd1);
      check("t1_cnt", 32'(my_cnt), 32'd3);
      check("t1_state_idle", 32'(my_state), 32'd0);

      // 2: invalid destination is drained.
      exp_strb.push_back(S_DEST);
      send_byte(8'hAA);
      send_byte(8'h07);
      send_byte(8'h02);
      check("t2_err_dest", {31'd0, err_dest}, 32'd1);
      check("t2_state_drop", 32'(my_state), 32'd4);
      send_byte(8'h55);
      send_byte(8'h66);
      send_csum(8'h36);
      check("t2_no_done", {31'd0, pkt_done}, 32'd0);
      check("t2_state_idle", 32'(my_state), 32'd0);

      // 3: backpressure on channel 1 longer than TIMEOUT.
      exp_data.push_back({8'd1, 8'hAB});
      exp_data.push_back({8'd1, 8'hCD});
      exp_strb.push_back(S_DONE);
      ready_bus[1] = 1'b0;
      send_byte(8'hAA);
      send_byte(8'h01);
      send_byte(8'h02);
      rx_data  = 8'hAB;
      rx_valid = 1'b1;
      repeat (5) @(negedge clk);
      check("t3_rx_ready_low", {31'd0, rx_ready}, 32'd0);
      check("t3_held", {23'd0, valid_bus[1], data_bus[15:8]}, {23'd0, 1'b1, 8'hAB});
      repeat (5) @(negedge clk);
      @(posedge clk);
      #1;
      check("t3_no_timeout", 32'(my_state), 32'd3);
      ready_bus[1] = 1'b1;
      send_byte(8'hAB);
      send_byte(8'hCD);
      send_csum(8'h65);
      check("t3_pkt_done", {31'd0, pkt_done}, 32'd1);

      // 4: silence mid-packet aborts after TIMEOUT idle cycles.
      exp_strb.push_back(S_TO);
      send_byte(8'hAA);
      send_byte(8'h00);
      send_byte(8'h05);
      repeat (TIMEOUT - 1) @(posedge clk);
      #1;
      check("t4_before_to", {28'd0, my_state, err_timeout}, {28'd0, 3'd3, 1'b0});
      @(posedge clk);
      #1;
      check("t4_err_timeout", {31'd0, err_timeout}, 32'd1);
      check("t4_state_idle", 32'(my_state), 32'd0);
      exp_data.push_back({8'd0, 8'h5A});
      exp_strb.push_back(S_DONE);
      send_byte(8'hAA);
      send_byte(8'h00);
      send_byte(8'h01);
      send_byte(8'h5A);
      send_csum(8'h5B);
      check("t4_pkt_done", {31'd0, pkt_done}, 32'd1);

      // 5: asynchronous reset mid-payload.
      exp_data.push_back({8'd2, 8'h11});
      send_byte(8'hAA);
      send_byte(8'h02);
      send_byte(8'h03);
      send_byte(8'h11);
      rx_data  = 8'h22;
      rx_valid = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      check("t5_rst_outputs", {15'd0, rx_ready, 8'(valid_bus), data_bus[23:16]}, 32'd0);
      check("t5_rst_regs", {my_state, my_cnt, my_dest, 13'd0}, 32'd0);
      rx_valid = 1'b0;
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      exp_strb.push_back(S_DONE);
      send_byte(8'hAA);
      send_byte(8'h03);
      send_byte(8'h00);
      send_csum(8'h03);
      check("t5_pkt_done", {31'd0, pkt_done}, 32'd1);
      check("t5_dest", 32'(my_dest), 32'd3);

`ifdef CMD_ROUTER_CHECKSUM_EN
      // 6: checksum match then mismatch.
      exp_data.push_back({8'd1, 8'h10});
      exp_strb.push_back(S_DONE);
      send_byte(8'hAA);
      send_byte(8'h01);
      send_byte(8'h01);
      send_byte(8'h10);
      send_byte(8'h10);
      check("t6_pkt_done", {31'd0, pkt_done}, 32'd1);
      exp_data.push_back({8'd1, 8'h10});
      exp_strb.push_back(S_CSUM);
      send_byte(8'hAA);
      send_byte(8'h01);
      send_byte(8'h01);
      send_byte(8'h10);
      send_byte(8'h11);
      check("t6_err_csum", {30'd0, err_csum, pkt_done}, 32'd2);
`else
      check("no_csum_strobe", {31'd0, err_csum}, 32'd0);
`endif

      repeat (4) @(posedge clk);
      #1;
      check("data_queue_drained", exp_data.size(), 32'd0);
      check("strobe_queue_drained", exp_strb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
